// File: rtl/stack_sequencer.sv
// Stack/subroutine sequencer: drives ARF (PC/AR/SP) controls and a byte-wide memory to run PUSH/POP/CALL/RET.
// Optional accept-time stack bounds checking is enabled by defining STACK_LIMIT_EN.
module stack_sequencer #(
  parameter logic [15:0] STACK_LIMIT = 16'h0100,
  parameter logic [15:0] STACK_TOP   = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [15:0] i_data_in,
  input  logic [15:0] i_target,
  output logic [15:0] o_data_out,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_arf_i,
  output logic [2:0]  o_arf_regsel,
  output logic [2:0]  o_arf_funsel,
  output logic [1:0]  o_arf_outcsel,
  output logic [1:0]  o_arf_outdsel,
  input  logic [15:0] i_arf_outc,
  input  logic [15:0] i_arf_outd,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wr_data,
  output logic        o_mem_wr,
  output logic        o_mem_rd,
  input  logic [7:0]  i_mem_rd_data
);
  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_t;
  typedef enum logic [2:0] {S_IDLE, S_DEC, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI, S_LOAD_PC, S_DONE} state_t;

  state_t      r_state, w_next;
  op_t         r_op, w_op;
  logic [15:0] r_w, r_target, r_data_out;
  logic        w_accept, w_reject;

  assign w_op     = op_t'(i_req_op);
  assign w_accept = (r_state == S_IDLE) && i_req_valid;

`ifdef STACK_LIMIT_EN
  logic r_rej;

  // 17-bit compares so the +2 / -1 bound adjustments cannot wrap
  always_comb begin
    w_reject = 1'b0;
    if (w_op == OP_PUSH || w_op == OP_CALL)
      w_reject = {1'b0, i_arf_outd} < ({1'b0, STACK_LIMIT} + 17'd2);
    else
      w_reject = {1'b0, i_arf_outd} > ({1'b0, STACK_TOP} - 17'd1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_rej <= 1'b0;
    else if (w_accept) r_rej <= w_reject;
  end

  assign o_err = (r_state == S_DONE) && r_rej;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{STACK_LIMIT, STACK_TOP};
  assign w_reject     = 1'b0;
  assign o_err        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject)                               w_next = S_DONE;
          else if (w_op == OP_PUSH || w_op == OP_CALL) w_next = S_DEC;
          else                                        w_next = S_RD_LO;
        end
      end
      S_DEC:     w_next = S_WR_HI;
      S_WR_HI:   w_next = S_WR_LO;
      S_WR_LO:   w_next = (r_op == OP_CALL) ? S_LOAD_PC : S_DONE;
      S_RD_LO:   w_next = S_RD_HI;
      S_RD_HI:   w_next = (r_op == OP_RET) ? S_LOAD_PC : S_DONE;
      S_LOAD_PC: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_arf_regsel  = 3'b111;
    o_arf_funsel  = 3'b000;
    o_arf_i       = '0;
    o_mem_wr      = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr_data = '0;
    case (r_state)
      S_DEC: o_arf_regsel = 3'b110;
      S_WR_HI: begin
        o_mem_wr      = 1'b1;
        o_mem_wr_data = r_w[15:8];
        o_arf_regsel  = 3'b110;
      end
      S_WR_LO: begin
        o_mem_wr      = 1'b1;
        o_mem_wr_data = r_w[7:0];
      end
      S_RD_LO, S_RD_HI: begin
        o_mem_rd     = 1'b1;
        o_arf_regsel = 3'b110;
        o_arf_funsel = 3'b001;
      end
      S_LOAD_PC: begin
        o_arf_regsel = 3'b011;
        o_arf_funsel = 3'b010;
        o_arf_i      = (r_op == OP_CALL) ? r_target : r_w;
      end
      default: ;
    endcase
  end

  // DataOut is loaded on the edge that enters DONE so it is valid alongside Done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w        <= '0;
      r_target   <= '0;
      r_op       <= OP_PUSH;
      r_data_out <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= w_op;
        r_target <= i_target;
        r_w      <= (w_op == OP_CALL) ? i_arf_outc : i_data_in;
      end
      if (r_state == S_RD_LO) r_w[7:0]  <= i_mem_rd_data;
      if (r_state == S_RD_HI) r_w[15:8] <= i_mem_rd_data;
      if (r_state == S_RD_HI && r_op == OP_POP)   r_data_out <= {i_mem_rd_data, r_w[7:0]};
      if (r_state == S_LOAD_PC && r_op == OP_RET) r_data_out <= r_w;
    end
  end

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_data_out    = r_data_out;
  assign o_mem_addr    = i_arf_outd;
  assign o_arf_outcsel = 2'b00;
  assign o_arf_outdsel = 2'b11;
endmodule
